// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: iterative radix-2 RV32M multiply/divide.
// Operates on operand magnitudes and applies the sign on the final step;
// divide-by-zero and signed overflow are resolved at start without iterating.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands and op decoded on the start cycle
// CALC  | one shift-add (mul) or restoring shift-subtract (div) per clock
// DONE  | result valid, done pulses for one cycle, then back to IDLE
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             sel_hi;    // mul: upper product word; div: remainder
   logic             neg_res;
   logic [WIDTH-1:0] acc_hi;    // mul: product high / div: partial remainder
   logic [WIDTH-1:0] acc_lo;    // mul: multiplier+product low / div: dividend->quotient
   logic [WIDTH-1:0] opnd;      // mul: multiplicand magnitude / div: divisor magnitude

   logic             op_div, a_signed, b_signed, sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero, div_ovf;
   logic [WIDTH-1:0] fast_val;

   // Decode the incoming request: operand signedness, magnitudes and fast paths.
   always_comb begin
      op_div   = funct3[2];
      a_signed = op_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_signed = op_div ? ~funct3[0] : ~funct3[1];
      sa       = a_signed & srca[WIDTH-1];
      sb       = b_signed & srcb[WIDTH-1];
      mag_a    = sa ? (~srca + 1'b1) : srca;
      mag_b    = sb ? (~srcb + 1'b1) : srcb;
      div_zero = op_div && (srcb == '0);
      div_ovf  = op_div && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
      if (div_zero) fast_val = funct3[1] ? srca : '1;
      else          fast_val = funct3[1] ? '0 : MIN_NEG;
   end

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shl;
   logic [WIDTH+1:0]   div_diff;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_raw, final_val;

   // One iteration step plus the sign fix-up applied on the last step.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shl  = {acc_hi, acc_lo[WIDTH-1]};
      div_diff = {1'b0, div_shl} - {2'b00, opnd};
      if (is_div) begin
         step_hi = div_diff[WIDTH+1] ? div_shl[WIDTH-1:0] : div_diff[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
      prod_fix = neg_res ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
      div_raw  = sel_hi ? step_hi : step_lo;
      if (is_div)
         final_val = neg_res ? (~div_raw + 1'b1) : div_raw;
      else
         final_val = sel_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
   end

   // Control FSM with registered busy/done/result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         sel_hi  <= 1'b0;
         neg_res <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (div_zero || div_ovf) begin
                     result <= fast_val;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     is_div  <= op_div;
                     sel_hi  <= op_div ? funct3[1] : (funct3[1:0] != 2'b00);
                     neg_res <= (op_div && funct3[1]) ? sa : (sa ^ sb);
                     acc_hi  <= '0;
                     acc_lo  <= op_div ? mag_a : mag_b;
                     opnd    <= op_div ? mag_b : mag_a;
                     cnt     <= CW'(WIDTH-1);
                     busy    <= 1'b1;
                     state   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  result <= final_val;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for muldiv_unit: expectations queued at start, checked on done.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  funct3;
   logic [31:0] srca, srcb;
   logic        busy, done;
   logic [31:0] result;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .srca(srca), .srcb(srcb), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int cyc = 0;
   int checks = 0, failures = 0;
   int done_seen = 0, busy_cnt = 0, first_busy = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference model built from plain SV arithmetic.
   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint as_ = longint'($signed(a));
      longint bs_ = longint'($signed(b));
      longint au_ = longint'({32'h0, a});
      longint bu_ = longint'({32'h0, b});
      longint p;
      int ia = a;
      int ib = b;
      case (f)
         3'b000: begin p = as_ * bs_; return p[31:0];  end
         3'b001: begin p = as_ * bs_; return p[63:32]; end
         3'b010: begin p = as_ * bu_; return p[63:32]; end
         3'b011: begin p = au_ * bu_; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Output monitor: counts busy cycles and pops the scoreboard on each done.
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
         end
         if (done) begin
            exp_t e;
            done_seen++;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk(e.tag, result, e.exp);
               chk({e.tag, "_cycle"}, cyc, e.due);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
      bit fast;
      int n0, c0, k;
      fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      n0 = done_seen;
      c0 = cyc;
      funct3 = f; srca = a; srcb = b; start = 1'b1;
      busy_cnt = 0; first_busy = -1;
      sb_q.push_back('{tag, e, c0 + (fast ? 1 : 33)});
      tick();
      start = 1'b0;
      srca = $urandom; srcb = $urandom; funct3 = 3'($urandom_range(0, 7));
      k = 0;
      while (done_seen == n0 && k < 45) begin
         tick();
         k++;
      end
      if (done_seen == n0) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         sb_q.delete();
      end
      chk({tag, "_busy_cycles"}, busy_cnt, fast ? 32'd0 : 32'd32);
      if (!fast) chk({tag, "_busy_first"}, first_busy, c0 + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n0, k;
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; funct3 = '0; srca = '0; srcb = '0;
      repeat (3) tick();
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_result", result, 32'h0);
      reset = 1'b0;
      tick();

      run_op("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD);
      run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF);
      run_op("divu_100_7",  3'b101, 32'd100,        32'd7,          32'd14);
      run_op("remu_100_7",  3'b111, 32'd100,        32'd7,          32'd2);
      run_op("divu_by0",    3'b101, 32'h1234,       32'd0,          32'hFFFF_FFFF);
      run_op("rem_by0",     3'b110, 32'h1234,       32'd0,          32'h0000_1234);
      run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

      for (int i = 0; i < 12; i++) begin
         rf = 3'(i % 8);
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, ref_md(rf, ra, rb));
      end

      // start held high: one op per IDLE visit; operands changed mid-flight
      c0 = cyc; n0 = done_seen;
      funct3 = 3'b000; srca = 32'd3; srcb = 32'd5; start = 1'b1;
      sb_q.push_back('{"held_1", 32'd15, c0 + 33});
      sb_q.push_back('{"held_2", 32'd45, c0 + 67});
      repeat (5) tick();
      srca = 32'd9;
      while (cyc < c0 + 40) tick();
      start = 1'b0;
      srca = 32'd1;
      k = 0;
      while (done_seen < n0 + 2 && k < 60) begin
         tick();
         k++;
      end
      chk("held_done_count", done_seen, n0 + 2);
      sb_q.delete();
      tick();

      // reset in the middle of a divide aborts it without a done pulse
      c0 = cyc;
      funct3 = 3'b100; srca = 32'd1000; srcb = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < c0 + 10) tick();
      chk("abort_busy_before", busy, 1'b1);
      reset = 1'b1;
      tick();
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, 32'h0);
      reset = 1'b0;
      repeat (40) tick();

      run_op("post_abort_mul", 3'b000, 32'd6, 32'd7, 32'd42);
      chk("queue_empty", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
